// File: rtl/phys_reg_free_list.sv
// Physical-register free list: circular FIFO of free physical indices.
// Released registers enter at the tail and are offered to rename from the head.
module phys_reg_free_list #(
  parameter int unsigned p_phys_addr_bits = 6,
  parameter int unsigned p_num_arch_regs  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        commit_val,
  input  logic                        commit_wen,
  input  logic [p_phys_addr_bits-1:0] commit_ppreg,
  output logic                        alloc_val,
  output logic [p_phys_addr_bits-1:0] alloc_preg,
  input  logic                        alloc_rdy,
  output logic [p_phys_addr_bits:0]   num_free,
  output logic                        overflow
);

  localparam int unsigned W     = p_phys_addr_bits;
  localparam int unsigned D     = (1 << p_phys_addr_bits) - p_num_arch_regs;
  localparam int unsigned CW    = p_phys_addr_bits + 1;
  localparam int unsigned PTR_W = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]     entries [D];
  logic [PTR_W-1:0] hd;
  logic [PTR_W-1:0] tl;
  logic [CW-1:0]    cnt;

  logic             rel;
  logic             fire;
  logic             full;
  logic             drop;
  logic             enq;
  logic [PTR_W-1:0] hd_nxt;
  logic [PTR_W-1:0] tl_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             overflow_nxt;

  // Wrap explicitly since the capacity need not be a power of two.
  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Offer comes straight from state so no input reaches alloc_val/alloc_preg.
  assign alloc_val  = (cnt != '0);
  assign alloc_preg = entries[hd];
  assign num_free   = cnt;

  // Next-state: qualify release/allocate and resolve the full-list corner.
  always_comb begin
    rel          = 1'b0;
    fire         = 1'b0;
    full         = 1'b0;
    drop         = 1'b0;
    enq          = 1'b0;
    hd_nxt       = hd;
    tl_nxt       = tl;
    cnt_nxt      = cnt;
    overflow_nxt = overflow;

    rel  = commit_val && commit_wen && (commit_ppreg != '0);
    fire = alloc_val && alloc_rdy;
    full = (cnt == CW'(D));
    drop = rel && full && !fire;
    enq  = rel && !drop;

    if (fire) hd_nxt = adv(hd);
    if (enq)  tl_nxt = adv(tl);
    if (drop) overflow_nxt = 1'b1;

    if (enq && !fire)      cnt_nxt = cnt + CW'(1);
    else if (!enq && fire) cnt_nxt = cnt - CW'(1);
  end

  // State register; reset reloads the list with every non-architectural register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(D); i++) begin
        entries[i] <= W'(p_num_arch_regs + 32'(i));
      end
      hd       <= '0;
      tl       <= '0;
      cnt      <= CW'(D);
      overflow <= 1'b0;
    end else begin
      if (enq) entries[tl] <= commit_ppreg;
      hd       <= hd_nxt;
      tl       <= tl_nxt;
      cnt      <= cnt_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list with a free-list scoreboard.
module tb_phys_reg_free_list;

  localparam int unsigned W = 6;
  localparam int unsigned D = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         commit_val;
  logic         commit_wen;
  logic [W-1:0] commit_ppreg;
  logic         alloc_val;
  logic [W-1:0] alloc_preg;
  logic         alloc_rdy;
  logic [W:0]   num_free;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] m_exp;
  logic         m_fire;
  logic         m_rel;
  logic         m_full;

  phys_reg_free_list #(.p_phys_addr_bits(6), .p_num_arch_regs(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_val   (commit_val),
    .commit_wen   (commit_wen),
    .commit_ppreg (commit_ppreg),
    .alloc_val    (alloc_val),
    .alloc_preg   (alloc_preg),
    .alloc_rdy    (alloc_rdy),
    .num_free     (num_free),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: at mid-cycle, pop the expected register on each allocation
  // and push each accepted release, mirroring the intended list behaviour.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      m_fire = (exp_q.size() != 0) && (alloc_rdy === 1'b1);
      m_rel  = (commit_val === 1'b1) && (commit_wen === 1'b1) && (commit_ppreg != '0);
      m_full = (exp_q.size() == D);
      checks++;
      if (alloc_val !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_alloc_val got %b expected %b at %0t", alloc_val, exp_q.size() != 0, $time);
      end
      if (m_fire) begin
        m_exp = exp_q.pop_front();
        checks++;
        if (alloc_preg !== m_exp) begin
          errors++;
          $display("FAIL sb_alloc_preg got %0d expected %0d at %0t", alloc_preg, m_exp, $time);
        end
      end
      if (m_rel && !(m_full && !m_fire)) exp_q.push_back(commit_ppreg);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    commit_val   = 1'b0;
    commit_wen   = 1'b0;
    commit_ppreg = '0;
    alloc_rdy    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(D); i++) exp_q.push_back(W'(32 + i));
    #1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (alloc_val !== 1'b1) begin errors++; $display("FAIL reset_val got %b expected 1", alloc_val); end
    checks++;
    if (alloc_preg !== W'(32)) begin errors++; $display("FAIL reset_preg got %0d expected 32", alloc_preg); end
    checks++;
    if (num_free !== 7'd32) begin errors++; $display("FAIL reset_num_free got %0d expected 32", num_free); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      alloc_rdy = 1'b1;
      checks++;
      if (alloc_preg !== W'(32 + i)) begin
        errors++;
        $display("FAIL drain_preg[%0d] got %0d expected %0d", i, alloc_preg, 32 + i);
      end
      tick();
    end
    alloc_rdy = 1'b0;
    checks++;
    if (alloc_val !== 1'b0) begin errors++; $display("FAIL drain_val got %b expected 0", alloc_val); end
    checks++;
    if (num_free !== 7'd0) begin errors++; $display("FAIL drain_num_free got %0d expected 0", num_free); end
  endtask

  task automatic test_empty_release();
    commit_val = 1'b1; commit_wen = 1'b1; commit_ppreg = W'(5); alloc_rdy = 1'b1;
    checks++;
    if (alloc_val !== 1'b0) begin errors++; $display("FAIL empty_rel_same_val got %b expected 0", alloc_val); end
    tick();
    idle_inputs();
    checks++;
    if (alloc_val !== 1'b1) begin errors++; $display("FAIL empty_rel_next_val got %b expected 1", alloc_val); end
    checks++;
    if (alloc_preg !== W'(5)) begin errors++; $display("FAIL empty_rel_preg got %0d expected 5", alloc_preg); end
    checks++;
    if (num_free !== 7'd1) begin errors++; $display("FAIL empty_rel_num_free got %0d expected 1", num_free); end
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
  endtask

  task automatic test_filtered();
    apply_reset();
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    commit_val = 1'b1; commit_wen = 1'b0; commit_ppreg = W'(7);
    tick();
    commit_val = 1'b1; commit_wen = 1'b1; commit_ppreg = W'(0);
    tick();
    commit_val = 1'b0; commit_wen = 1'b1; commit_ppreg = W'(7);
    tick();
    idle_inputs();
    checks++;
    if (num_free !== 7'd31) begin errors++; $display("FAIL filtered_num_free got %0d expected 31", num_free); end
    checks++;
    if (alloc_preg !== W'(33)) begin errors++; $display("FAIL filtered_preg got %0d expected 33", alloc_preg); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL filtered_overflow got %b expected 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp;
    apply_reset();
    alloc_rdy = 1'b1;
    repeat (3) tick();
    alloc_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit_val = 1'b1; commit_wen = 1'b1; commit_ppreg = W'(40 + i);
      tick();
    end
    idle_inputs();
    checks++;
    if (num_free !== 7'd32) begin errors++; $display("FAIL wrap_full_num_free got %0d expected 32", num_free); end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 29) ? W'(35 + i) : W'(40 + i - 29);
      alloc_rdy = 1'b1;
      checks++;
      if (alloc_preg !== exp) begin
        errors++;
        $display("FAIL wrap_preg[%0d] got %0d expected %0d", i, alloc_preg, exp);
      end
      tick();
    end
    alloc_rdy = 1'b0;
    checks++;
    if (num_free !== 7'd0) begin errors++; $display("FAIL wrap_num_free got %0d expected 0", num_free); end
  endtask

  task automatic test_full();
    logic [W-1:0] exp;
    apply_reset();
    commit_val = 1'b1; commit_wen = 1'b1; commit_ppreg = W'(9);
    tick();
    idle_inputs();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_drop_overflow got %b expected 1", overflow); end
    checks++;
    if (num_free !== 7'd32) begin errors++; $display("FAIL full_drop_num_free got %0d expected 32", num_free); end
    checks++;
    if (alloc_preg !== W'(32)) begin errors++; $display("FAIL full_drop_preg got %0d expected 32", alloc_preg); end
    tick();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_sticky_overflow got %b expected 1", overflow); end

    apply_reset();
    commit_val = 1'b1; commit_wen = 1'b1; commit_ppreg = W'(9); alloc_rdy = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_fire_overflow got %b expected 0", overflow); end
    checks++;
    if (num_free !== 7'd32) begin errors++; $display("FAIL full_fire_num_free got %0d expected 32", num_free); end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 31) ? W'(33 + i) : W'(9);
      alloc_rdy = 1'b1;
      checks++;
      if (alloc_preg !== exp) begin
        errors++;
        $display("FAIL full_fire_preg[%0d] got %0d expected %0d", i, alloc_preg, exp);
      end
      tick();
    end
    alloc_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      alloc_rdy    = ($urandom_range(0, 3) != 0);
      commit_val   = ($urandom_range(0, 3) != 0);
      commit_wen   = ($urandom_range(0, 7) != 0);
      commit_ppreg = W'($urandom_range(0, 63));
      tick();
    end
    idle_inputs();
    checks++;
    if (num_free !== 7'(exp_q.size())) begin
      errors++;
      $display("FAIL b2b_num_free got %0d expected %0d", num_free, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_rdy = 1'b1;
    repeat (10) tick();
    alloc_rdy = 1'b0;
    checks++;
    if (alloc_preg !== W'(42)) begin errors++; $display("FAIL async_pre_preg got %0d expected 42", alloc_preg); end
    #2;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(D); i++) exp_q.push_back(W'(32 + i));
    #1;
    checks++;
    if (alloc_preg !== W'(32)) begin errors++; $display("FAIL async_preg got %0d expected 32", alloc_preg); end
    checks++;
    if (num_free !== 7'd32) begin errors++; $display("FAIL async_num_free got %0d expected 32", num_free); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got %b expected 0", overflow); end
    checks++;
    if (alloc_val !== 1'b1) begin errors++; $display("FAIL async_val got %b expected 1", alloc_val); end
    tick();
    rst = 1'b1;
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    checks++;
    if (alloc_preg !== W'(33)) begin errors++; $display("FAIL async_post_preg got %0d expected 33", alloc_preg); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_drain();
    test_empty_release();
    test_filtered();
    test_wrap();
    test_full();
    test_back_to_back();
    test_async_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
